// File: rtl/matrix_row_loader_if.sv
// Row-loader bus: element stream in (valid/ready) and the row-write port out to matrix_buffer.
// The master modport is the loader side and the slave modport is the environment side (DDR feed plus buffer).
interface matrix_row_loader_if #(
  parameter int INPUT_WIDTH = 8,
  parameter int MATRIX_SIZE = 3
);
  logic                               in_valid;
  logic [INPUT_WIDTH-1:0]             in_data;
  logic                               in_ready;
  logic                               buf_read_EN;
  logic                               K_V_write_EN;
  logic                               K_V_sel;
  logic [INPUT_WIDTH*MATRIX_SIZE-1:0] MATRIX_INPUT;

  modport master (
    input  in_valid, in_data, buf_read_EN,
    output in_ready, K_V_write_EN, K_V_sel, MATRIX_INPUT
  );

  modport slave (
    output in_valid, in_data, buf_read_EN,
    input  in_ready, K_V_write_EN, K_V_sel, MATRIX_INPUT
  );
endinterface

// File: rtl/matrix_row_loader.sv
// matrix_row_loader: packs a serial stream of signed elements into rows and writes
// MATRIX_SIZE rows into matrix_buffer for each start command.
// A row write is held off while the buffer is reading, because a read wins inside the buffer.
module matrix_row_loader #(
  parameter int INPUT_WIDTH = 8,
  parameter int MATRIX_SIZE = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sel,
  matrix_row_loader_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam int ROW_W = INPUT_WIDTH * MATRIX_SIZE;
  localparam int CNT_W = $clog2(MATRIX_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MATRIX_SIZE - 1);

  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   elem_cnt_q, elem_cnt_d;
  logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic               sel_q, sel_d;
  logic [ROW_W-1:0]   row_q, row_d;        // row under construction
  logic [ROW_W-1:0]   out_row_q, out_row_d; // row presented to the buffer
  logic               kv_sel_q, kv_sel_d;
  logic               busy_q, done_q;
  logic [ROW_W-1:0]   pack_row;
  logic               in_ready_c;
  logic               wr_en_c;

  // Drop the incoming element into its lane; element 0 sits in the most significant lane.
  for (genvar gi = 0; gi < MATRIX_SIZE; gi++) begin : g_lane
    localparam int HI = (MATRIX_SIZE - gi) * INPUT_WIDTH - 1;
    assign pack_row[HI -: INPUT_WIDTH] =
      (elem_cnt_q == CNT_W'(gi)) ? bus.in_data : row_q[HI -: INPUT_WIDTH];
  end

  // Next-state and datapath decode; ready and the strobe are decoded from the current state.
  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    row_cnt_d  = row_cnt_q;
    sel_d      = sel_q;
    row_d      = row_q;
    out_row_d  = out_row_q;
    kv_sel_d   = kv_sel_q;
    in_ready_c = 1'b0;
    wr_en_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sel_d      = sel;
          elem_cnt_d = '0;
          row_cnt_d  = '0;
          state_d    = PACK;
        end
      end
      PACK: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          row_d = pack_row;
          if (elem_cnt_q == LAST) begin
            // Full row: hand it to the output register so it is stable for the strobe.
            elem_cnt_d = '0;
            out_row_d  = pack_row;
            kv_sel_d   = sel_q;
            state_d    = WRITE;
          end else begin
            elem_cnt_d = elem_cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        // The strobe is qualified by the live read flag so it can never land on a buffer read.
        if (!bus.buf_read_EN) begin
          wr_en_c   = 1'b1;
          row_cnt_d = row_cnt_q + CNT_W'(1);
          state_d   = (row_cnt_q == LAST) ? DONE : PACK;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial row and clears all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      elem_cnt_q <= '0;
      row_cnt_q  <= '0;
      sel_q      <= 1'b0;
      row_q      <= '0;
      out_row_q  <= '0;
      kv_sel_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      row_cnt_q  <= row_cnt_d;
      sel_q      <= sel_d;
      row_q      <= row_d;
      out_row_q  <= out_row_d;
      kv_sel_q   <= kv_sel_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.K_V_write_EN = wr_en_c;
  assign bus.K_V_sel      = kv_sel_q;
  assign bus.MATRIX_INPUT = out_row_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
